// File: rtl/aidan_mcnay_piso.sv
// Parallel-in serial-out shifter: valid/ready word load, MSB-first bit stream
// advanced by en, with a last-bit flag for framing.
module aidan_mcnay_piso #(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_val,
  output logic             load_rdy,
  input  logic [nbits-1:0] load_data,
  input  logic             en,
  output logic             data_out,
  output logic             out_val,
  output logic             out_last
);

  localparam int CW = $clog2(nbits + 1);
  localparam logic [CW-1:0] FULL = CW'(nbits);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [nbits-1:0] shreg;
  logic [CW-1:0]    count;
  logic             accept;
  logic             consume;

  assign out_val  = (count != '0);
  assign out_last = (count == ONE);
  assign data_out = out_val & shreg[nbits-1];

  // Ready on the final bit too, so a new word follows with no bubble.
  assign load_rdy = (count == '0) | (en & out_last);
  assign accept   = load_val & load_rdy;
  assign consume  = en & out_val & ~accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      count <= '0;
    end else if (accept) begin
      shreg <= load_data;
      count <= FULL;
    end else if (consume) begin
      shreg <= shreg << 1;
      count <= count - ONE;
    end
  end

endmodule

// File: tb/tb_aidan_mcnay_piso.sv
// Randomized and directed bench for aidan_mcnay_piso against a bit-queue model.
module tb_aidan_mcnay_piso;
  logic        clk = 1'b0;
  logic        reset;
  logic        load_val;
  logic        load_rdy;
  logic [15:0] load_data;
  logic        en;
  logic        data_out;
  logic        out_val;
  logic        out_last;
  logic [15:0] sipo = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit q[$];   // bits still to be emitted, front = current bit

  aidan_mcnay_piso #(.nbits(16)) dut (
    .clk(clk), .reset(reset), .load_val(load_val), .load_rdy(load_rdy),
    .load_data(load_data), .en(en), .data_out(data_out),
    .out_val(out_val), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Downstream SIPO sharing en
  always @(posedge clk) if (en) sipo <= {sipo[14:0], data_out};

  function automatic bit m_val();  return q.size() != 0; endfunction
  function automatic bit m_last(); return q.size() == 1; endfunction
  function automatic bit m_data(); return (q.size() != 0) ? q[0] : 1'b0; endfunction
  function automatic bit m_rdy();  return (q.size() == 0) || (en && q.size() == 1); endfunction

  task automatic drive(input bit lv, input logic [15:0] ld, input bit e);
    load_val  = lv;
    load_data = ld;
    en        = e;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    bit acc, con;
    acc = load_val && m_rdy();
    con = en && m_val();
    @(posedge clk);
    if (acc) begin
      q.delete();
      for (int i = 15; i >= 0; i--) q.push_back(load_data[i]);
    end else if (con) begin
      void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 16'h0, 0);
    q.delete();
    #3;
    n_checks++; if (out_val !== 1'b0)  begin n_fail++; $display("FAIL reset_out_val got=%b exp=0", out_val); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    n_checks++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL reset_data_out got=%b exp=0", data_out); end
    n_checks++; if (load_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_load_rdy got=%b exp=1", load_rdy); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_stream();
    logic [15:0] w;
    w = 16'hA5C3;
    drive(1, w, 1);
    #1;
    n_checks++; if (load_rdy !== 1'b1) begin n_fail++; $display("FAIL stream_rdy got=%b exp=1", load_rdy); end
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(0, 16'h0, 1);
      #1;
      n_checks++; if (data_out !== w[15-k]) begin n_fail++; $display("FAIL stream_bit%0d got=%b exp=%b", k, data_out, w[15-k]); end
      n_checks++; if (out_val !== 1'b1) begin n_fail++; $display("FAIL stream_val%0d got=%b exp=1", k, out_val); end
      n_checks++; if (out_last !== (k == 15)) begin n_fail++; $display("FAIL stream_last%0d got=%b exp=%b", k, out_last, (k == 15)); end
      tick();
    end
    #1;
    n_checks++; if (out_val !== 1'b0)  begin n_fail++; $display("FAIL stream_end_val got=%b exp=0", out_val); end
    n_checks++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL stream_end_data got=%b exp=0", data_out); end
    n_checks++; if (load_rdy !== 1'b1) begin n_fail++; $display("FAIL stream_end_rdy got=%b exp=1", load_rdy); end
  endtask

  task automatic test_loopback();
    drive(1, 16'h8001, 1);
    tick();
    for (int c = 0; c < 32; c++) begin
      drive(c == 15, 16'h7FFE, 1);
      #1;
      if (c == 15) begin
        n_checks++; if (load_rdy !== 1'b1) begin n_fail++; $display("FAIL loop_rdy got=%b exp=1", load_rdy); end
      end
      tick();
      if (c == 15) begin
        n_checks++; if (sipo !== 16'h8001) begin n_fail++; $display("FAIL loop_word0 got=%h exp=8001", sipo); end
      end
    end
    n_checks++; if (sipo !== 16'h7FFE) begin n_fail++; $display("FAIL loop_word1 got=%h exp=7ffe", sipo); end
  endtask

  task automatic test_stall();
    logic [15:0] w;
    bit pat[4] = '{1, 0, 0, 1};
    int consumed;
    w = 16'hF00F;
    consumed = 0;
    drive(1, w, 0);
    tick();
    // pattern 1,0,0,1 gives two consumes per 4 cycles: 16 bits span 32 cycles
    for (int cyc = 0; cyc < 32; cyc++) begin
      drive(0, 16'h0, pat[cyc % 4]);
      #1;
      n_checks++; if (out_val !== 1'b1) begin n_fail++; $display("FAIL stall_val cyc%0d got=%b exp=1", cyc, out_val); end
      n_checks++; if (data_out !== w[15-consumed]) begin n_fail++; $display("FAIL stall_bit cyc%0d got=%b exp=%b", cyc, data_out, w[15-consumed]); end
      tick();
      if (pat[cyc % 4]) consumed++;
    end
    #1;
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL stall_end_val got=%b exp=0", out_val); end
  endtask

  task automatic test_back_to_back();
    bit got[$];
    bit exp_bits[$];
    bit lv;
    lv = 1'b0;
    for (int i = 0; i < 16; i++) exp_bits.push_back(1'b1);
    for (int i = 0; i < 15; i++) exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b1);
    drive(1, 16'hFFFF, 1);
    tick();
    for (int c = 0; c < 32; c++) begin
      drive(0, 16'h0001, 1);
      #1;
      if (c < 16 && out_last === 1'b1) begin
        drive(1, 16'h0001, 1);
        #1;
        n_checks++; if (load_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy got=%b exp=1", load_rdy); end
      end
      n_checks++; if (out_val !== 1'b1) begin n_fail++; $display("FAIL b2b_val cyc%0d got=%b exp=1", c, out_val); end
      got.push_back(data_out);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      n_checks++; if (got[i] !== exp_bits[i]) begin n_fail++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, got[i], exp_bits[i]); end
    end
  endtask

  task automatic test_illegal_load();
    logic [15:0] w0, w1;
    w0 = 16'hAAAA;
    w1 = 16'h1234;
    drive(1, w0, 1);
    tick();
    for (int k = 0; k < 32; k++) begin
      // 0x1234 offered from bit 5 and held until the handshake completes
      drive(k >= 5 && k < 16, w1, 1);
      #1;
      if (k >= 5 && k < 15) begin
        n_checks++; if (load_rdy !== 1'b0) begin n_fail++; $display("FAIL illegal_rdy bit%0d got=%b exp=0", k, load_rdy); end
      end
      if (k < 16) begin
        n_checks++; if (data_out !== w0[15-k]) begin n_fail++; $display("FAIL illegal_w0 bit%0d got=%b exp=%b", k, data_out, w0[15-k]); end
      end else begin
        n_checks++; if (data_out !== w1[31-k]) begin n_fail++; $display("FAIL illegal_w1 bit%0d got=%b exp=%b", k-16, data_out, w1[31-k]); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] w;
    w = 16'($urandom) | 16'h0100;  // bit 7 of the stream (w[8]) is 1
    drive(1, w, 1);
    tick();
    for (int k = 0; k < 7; k++) begin drive(0, 16'h0, 1); tick(); end
    drive(0, 16'h0, 0);
    #2;
    n_checks++; if (data_out !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_bit7 got=%b exp=1", data_out); end
    #1;
    reset = 1'b0;
    q.delete();
    #1;
    n_checks++; if (out_val !== 1'b0)  begin n_fail++; $display("FAIL rmid_val got=%b exp=0", out_val); end
    n_checks++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL rmid_data got=%b exp=0", data_out); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rmid_last got=%b exp=0", out_last); end
    n_checks++; if (load_rdy !== 1'b1) begin n_fail++; $display("FAIL rmid_rdy got=%b exp=1", load_rdy); end
    @(negedge clk);
    reset = 1'b1;
    w = 16'h0F0F;
    drive(1, w, 1);
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(0, 16'h0, 1);
      #1;
      n_checks++; if (data_out !== w[15-k] || out_val !== 1'b1) begin n_fail++; $display("FAIL rmid_fresh bit%0d got=%b/%b exp=%b/1", k, data_out, out_val, w[15-k]); end
      tick();
    end
  endtask

  task automatic test_random();
    bit pending;
    logic [15:0] w;
    pending = 1'b0;
    w = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pending && $urandom_range(0, 2) == 0) begin
        pending = 1'b1;
        w = 16'($urandom);
      end
      drive(pending, pending ? w : 16'($urandom), $urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (out_val !== m_val() || out_last !== m_last() || data_out !== m_data() || load_rdy !== m_rdy()) begin
        n_fail++;
        $display("FAIL random cyc%0d got val/last/data/rdy=%b%b%b%b exp=%b%b%b%b", c,
                 out_val, out_last, data_out, load_rdy, m_val(), m_last(), m_data(), m_rdy());
      end
      if (load_val && m_rdy()) pending = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_loopback();
    test_stall();
    test_back_to_back();
    test_illegal_load();
    test_reset_mid_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
